// File: rtl/photocell_conditioner.sv
// Photocell front end: synchronizes and debounces the two beam sensors, detects
// stuck-blocked sensors and turns accepted passages into gated one-cycle pulses.

module photocell_channel #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic       clck,
  input  logic       rst,
  input  logic       raw,
  output logic       pass,
  output logic       fault,
  output logic [1:0] state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, BLOCKED = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [3:0]  DEB   = DEB_CYCLES[3:0];
  localparam logic [15:0] STUCK = STUCK_CYCLES[15:0];

  state_t      state, state_n;
  logic        s1, s;
  logic [3:0]  dcnt, dcnt_n, dcnt_inc;
  logic [15:0] bcnt, bcnt_n, bcnt_inc;

  always_ff @(posedge clck) begin
    if (!rst) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      dcnt  <= '0;
      bcnt  <= '0;
    end else begin
      s1    <= raw;
      s     <= s1;
      state <= state_n;
      dcnt  <= dcnt_n;
      bcnt  <= bcnt_n;
    end
  end

  assign dcnt_inc = dcnt + 4'd1;
  assign bcnt_inc = bcnt + 16'd1;

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    bcnt_n  = bcnt;
    pass    = 1'b0;
    case (state)
      IDLE: begin
        if (!s) begin
          dcnt_n = '0;
        end else if (dcnt_inc == DEB) begin
          state_n = BLOCKED;
          dcnt_n  = '0;
          bcnt_n  = '0;
        end else begin
          dcnt_n = dcnt_inc;
        end
      end
      BLOCKED: begin
        bcnt_n = (bcnt == STUCK) ? bcnt : bcnt_inc;
        // A stuck timeout wins over a release qualifying on the same cycle.
        if (bcnt_inc == STUCK) begin
          state_n = FAULT;
        end else if (s) begin
          dcnt_n = '0;
        end else if (dcnt_inc == DEB) begin
          state_n = IDLE;
          dcnt_n  = '0;
          pass    = 1'b1;
        end else begin
          dcnt_n = dcnt_inc;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
        dcnt_n  = '0;
        bcnt_n  = '0;
      end
    endcase
  end

  assign fault     = (state == FAULT);
  assign state_dbg = state;
endmodule

module photocell_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic       clck,
  input  logic       rst,
  input  logic       FE_raw,
  input  logic       BE_raw,
  input  logic       full_flag,
  input  logic       empt_flag,
  output logic       FE_photocell,
  output logic       BE_photocell,
  output logic       FE_fault,
  output logic       BE_fault,
  output logic [3:0] drop_cnt,
  output logic [1:0] fe_state,
  output logic [1:0] be_state
);
  logic       fe_pass, be_pass, fe_drop, be_drop;
  logic [4:0] drop_sum;

  photocell_channel #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_fe (
    .clck(clck), .rst(rst), .raw(FE_raw),
    .pass(fe_pass), .fault(FE_fault), .state_dbg(fe_state)
  );

  photocell_channel #(.DEB_CYCLES(DEB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_be (
    .clck(clck), .rst(rst), .raw(BE_raw),
    .pass(be_pass), .fault(BE_fault), .state_dbg(be_state)
  );

  // Arrivals are refused when the queue is full, departures when it is empty.
  assign fe_drop  = fe_pass & full_flag;
  assign be_drop  = be_pass & empt_flag;
  assign drop_sum = {1'b0, drop_cnt} + {4'd0, fe_drop} + {4'd0, be_drop};

  always_ff @(posedge clck) begin
    if (!rst) begin
      FE_photocell <= 1'b0;
      BE_photocell <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      FE_photocell <= fe_pass & ~full_flag;
      BE_photocell <= be_pass & ~empt_flag;
      drop_cnt     <= (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];
    end
  end
endmodule

// File: tb/tb_photocell_conditioner.sv
// Bench for photocell_conditioner: vector table, corner-case sequences and
// random traffic checked cycle by cycle against a level/run-length model.

module tb_photocell_conditioner;
  localparam int DEB   = 4;
  localparam int STUCK = 1000;

  logic       clck = 1'b0;
  logic       rst = 1'b0;
  logic       FE_raw = 1'b0, BE_raw = 1'b0, full_flag = 1'b0, empt_flag = 1'b0;
  logic       FE_photocell, BE_photocell, FE_fault, BE_fault;
  logic [3:0] drop_cnt;
  logic [1:0] fe_state, be_state;

  photocell_conditioner #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
    .clck(clck), .rst(rst), .FE_raw(FE_raw), .BE_raw(BE_raw),
    .full_flag(full_flag), .empt_flag(empt_flag),
    .FE_photocell(FE_photocell), .BE_photocell(BE_photocell),
    .FE_fault(FE_fault), .BE_fault(BE_fault), .drop_cnt(drop_cnt),
    .fe_state(fe_state), .be_state(be_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clck = ~clck;

  int tests = 0;
  int fails = 0;
  int fe_seen = 0;
  int be_seen = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clck);
  endtask

  task automatic do_reset();
    @(negedge clck);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel holds an accepted level; a synchronized value that disagrees
  // with it for DEB consecutive cycles flips the level. Blocked time is the
  // age of the current '1' level; reaching STUCK latches a fault.
  logic [7:0] exp_q[$];
  bit  m_s1[2], m_s2[2], m_level[2], m_fault[2], m_pulse[2];
  int  m_run[2], m_age[2], m_drop;
  bit  m_raw[2], m_gate[2], m_s, m_pass;

  always @(posedge clck) begin
    m_raw[0]  = FE_raw;    m_raw[1]  = BE_raw;
    m_gate[0] = full_flag; m_gate[1] = empt_flag;
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_level[c] = 0; m_fault[c] = 0;
        m_pulse[c] = 0; m_run[c] = 0; m_age[c] = 0;
      end
      m_drop = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_s = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = m_raw[c];
        m_pass = 0;
        if (!m_fault[c]) begin
          if (m_level[c]) begin
            if (m_age[c] + 1 >= STUCK) m_fault[c] = 1;
            else m_age[c]++;
          end
          if (!m_fault[c]) begin
            if (m_s != m_level[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == DEB) begin
              m_pass     = m_level[c];
              m_level[c] = !m_level[c];
              m_run[c]   = 0;
              m_age[c]   = 0;
            end
          end
        end
        m_pulse[c] = m_pass && !m_gate[c];
        if (m_pass && m_gate[c] && m_drop < 15) m_drop++;
      end
    end
    exp_q.push_back({m_pulse[0], m_pulse[1], m_fault[0], m_fault[1], 4'(m_drop)});
  end

  // ---------------- scoreboard ----------------
  logic [7:0] sb_got, sb_exp;
  always @(negedge clck) begin
    if (FE_photocell === 1'b1) fe_seen++;
    if (BE_photocell === 1'b1) be_seen++;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_got = {FE_photocell, BE_photocell, FE_fault, BE_fault, drop_cnt};
      tests++;
      if (sb_got !== sb_exp) begin
        fails++;
        $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, sb_got, sb_exp);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int   fe_len;
    int   be_len;
    logic full;
    logic empt;
    int   exp_fe;
    int   exp_be;
    int   exp_drop;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input int idx, input vec_t v);
    int f0, b0;
    do_reset();
    full_flag = v.full;
    empt_flag = v.empt;
    f0 = fe_seen;
    b0 = be_seen;
    FE_raw = (v.fe_len > 0);
    BE_raw = (v.be_len > 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (i == v.fe_len) FE_raw = 1'b0;
      if (i == v.be_len) BE_raw = 1'b0;
    end
    cyc(15);
    check($sformatf("vec%0d_fe_pulses", idx), fe_seen - f0, v.exp_fe);
    check($sformatf("vec%0d_be_pulses", idx), be_seen - b0, v.exp_be);
    check($sformatf("vec%0d_drop_cnt", idx), int'(drop_cnt), v.exp_drop);
    full_flag = 1'b0;
    empt_flag = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int f0, b0, lat, tf;

    vecs[0] = '{20,  0, 1'b0, 1'b0, 1, 0, 0};
    vecs[1] = '{ 0, 20, 1'b0, 1'b0, 0, 1, 0};
    vecs[2] = '{20, 20, 1'b0, 1'b0, 1, 1, 0};
    vecs[3] = '{20,  0, 1'b1, 1'b0, 0, 0, 1};
    vecs[4] = '{ 0, 20, 1'b0, 1'b1, 0, 0, 1};
    vecs[5] = '{20, 20, 1'b1, 1'b1, 0, 0, 2};
    vecs[6] = '{ 3,  0, 1'b0, 1'b0, 0, 0, 0};
    vecs[7] = '{ 4,  0, 1'b0, 1'b0, 1, 0, 0};
    vecs[8] = '{20,  0, 1'b0, 1'b1, 1, 0, 0};
    vecs[9] = '{ 0, 20, 1'b1, 1'b0, 0, 1, 0};

    cyc(3);
    check("reset_fe_pulse", int'(FE_photocell), 0);
    check("reset_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Release latency: pulse on the 6th edge after the raw fall.
    do_reset();
    FE_raw = 1'b1;
    cyc(20);
    FE_raw = 1'b0;
    lat = 0;
    f0 = fe_seen;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clck); #1;
      if (FE_photocell && lat == 0) lat = k;
    end
    check("fe_release_latency", lat, 2 + DEB);
    cyc(5);
    check("latency_single_pulse", fe_seen - f0, 1);

    // Glitch train of 3-cycle pulses is rejected.
    do_reset();
    f0 = fe_seen;
    repeat (5) begin
      FE_raw = 1'b1; cyc(3);
      FE_raw = 1'b0; cyc(3);
    end
    cyc(10);
    check("glitch_train_pulses", fe_seen - f0, 0);
    check("glitch_train_fault", int'(FE_fault), 0);

    // Alternating dropped passages saturate drop_cnt.
    do_reset();
    f0 = fe_seen;
    b0 = be_seen;
    repeat (10) begin
      full_flag = 1'b1; FE_raw = 1'b1; cyc(10); FE_raw = 1'b0; cyc(10); full_flag = 1'b0;
      empt_flag = 1'b1; BE_raw = 1'b1; cyc(10); BE_raw = 1'b0; cyc(10); empt_flag = 1'b0;
    end
    check("sat_drop_cnt", int'(drop_cnt), 15);
    check("sat_pulses", (fe_seen - f0) + (be_seen - b0), 0);

    // Stuck back-end sensor: fault on edge 2+DEB+STUCK, sticky until reset.
    do_reset();
    BE_raw = 1'b1;
    tf = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clck); #1;
      if (BE_fault && tf == 0) tf = k;
    end
    check("be_fault_time", tf, 2 + DEB + STUCK);
    @(negedge clck);
    BE_raw = 1'b0;
    b0 = be_seen;
    cyc(20);
    check("fault_no_pulse", be_seen - b0, 0);
    check("fault_sticky", int'(BE_fault), 1);
    rst = 1'b0;
    @(posedge clck); #1;
    check("fault_cleared_by_reset", int'(BE_fault), 0);
    @(negedge clck);
    rst = 1'b1;

    // Reset mid-passage: beam re-qualified, exactly one pulse.
    do_reset();
    FE_raw = 1'b1;
    cyc(10);
    f0 = fe_seen;
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(10);
    FE_raw = 1'b0;
    cyc(15);
    check("mid_reset_one_pulse", fe_seen - f0, 1);

    // Random traffic with occasional resets, checked by the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clck);
      if ($urandom_range(0, 7) == 0) FE_raw = ~FE_raw;
      if ($urandom_range(0, 7) == 0) BE_raw = ~BE_raw;
      full_flag = ($urandom_range(0, 3) == 0);
      empt_flag = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) != 0);
    end
    rst = 1'b1;
    FE_raw = 1'b0;
    BE_raw = 1'b0;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
